// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, captures ROM words into IF/ID, traps misaligned
// redirects and counts instructions delivered to decode.
module fetch_stage #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 'h0000_0000,
  parameter logic [ADDRESS_WIDTH-1:0] TRAP_PC       = 'h0000_0FF0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_stall_f,
  input  logic                     i_stall_d,
  input  logic                     i_flush_d,
  input  logic                     i_pc_src,
  input  logic [ADDRESS_WIDTH-1:0] i_pc_target,
  input  logic [DATA_WIDTH-1:0]    i_instr_f,
  output logic [ADDRESS_WIDTH-1:0] o_pc_f,
  output logic [DATA_WIDTH-1:0]    o_instr_d,
  output logic [ADDRESS_WIDTH-1:0] o_pc_d,
  output logic [ADDRESS_WIDTH-1:0] o_pc_plus4_d,
  output logic                     o_valid_d,
  output logic                     o_trap,
  output logic [ADDRESS_WIDTH-1:0] o_bad_addr,
  output logic [31:0]              o_fetch_count
);

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0]    r_instr_d;
  logic [ADDRESS_WIDTH-1:0] r_pc_d;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4_d;
  logic                     r_valid_d;
  logic                     r_trap;
  logic [ADDRESS_WIDTH-1:0] r_bad_addr;
  logic [31:0]              r_fetch_count;

  logic                     w_misaligned;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
  logic [ADDRESS_WIDTH-1:0] w_pc_next;

  assign w_misaligned = i_pc_src && (i_pc_target[1:0] != 2'b00);
  assign w_pc_plus4   = r_pc + ADDRESS_WIDTH'(4);

  // Redirect wins over stall_f; a misaligned target diverts to the trap vector.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_misaligned) begin
      w_pc_next = TRAP_PC;
    end else if (i_pc_src) begin
      w_pc_next = i_pc_target;
    end else if (i_stall_f) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_trap        <= 1'b0;
      r_bad_addr    <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_trap        <= w_misaligned;
      if (w_misaligned) begin
        r_bad_addr  <= i_pc_target;
      end
    end
  end

  // IF/ID register: flush beats stall; only a real capture counts as a delivery.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= '0;
      r_pc_plus4_d  <= '0;
      r_valid_d     <= 1'b0;
      r_fetch_count <= '0;
    end else if (i_flush_d) begin
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= '0;
      r_pc_plus4_d  <= '0;
      r_valid_d     <= 1'b0;
    end else if (!i_stall_d) begin
      r_instr_d     <= i_instr_f;
      r_pc_d        <= r_pc;
      r_pc_plus4_d  <= w_pc_plus4;
      r_valid_d     <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_pc_f        = r_pc;
  assign o_instr_d     = r_instr_d;
  assign o_pc_d        = r_pc_d;
  assign o_pc_plus4_d  = r_pc_plus4_d;
  assign o_valid_d     = r_valid_d;
  assign o_trap        = r_trap;
  assign o_bad_addr    = r_bad_addr;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random stimulus,
// all outputs compared every cycle against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] TrapPc = 32'h0000_0FF0;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] instr_f;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, bad_addr, fetch_count;
  logic        valid_d, trap;

  logic [31:0] rom [0:1023];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Combinational byte-addressed ROM decoding pc_f[11:0].
  assign instr_f = rom[pc_f[11:2]];

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall_f     (stall_f),
    .i_stall_d     (stall_d),
    .i_flush_d     (flush_d),
    .i_pc_src      (pc_src),
    .i_pc_target   (pc_target),
    .i_instr_f     (instr_f),
    .o_pc_f        (pc_f),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_pc_plus4_d  (pc_plus4_d),
    .o_valid_d     (valid_d),
    .o_trap        (trap),
    .o_bad_addr    (bad_addr),
    .o_fetch_count (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: what the architecture says each output must be after every edge.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_pcd, m_pcd4, m_bad, m_cnt;
  logic        m_valid, m_trap;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_pc = 32'h0; m_instr = Nop; m_pcd = 32'h0; m_pcd4 = 32'h0;
      m_valid = 1'b0; m_trap = 1'b0; m_bad = 32'h0; m_cnt = 32'h0;
    end else begin
      m_word = rom[m_pc[11:2]];
      if (flush_d) begin
        m_instr = Nop; m_pcd = 32'h0; m_pcd4 = 32'h0; m_valid = 1'b0;
      end else if (!stall_d) begin
        m_instr = m_word; m_pcd = m_pc; m_pcd4 = m_pc + 32'd4; m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
      m_trap = pc_src && (pc_target % 4 != 0);
      if (m_trap) m_bad = pc_target;
      if (pc_src) m_pc = m_trap ? TrapPc : pc_target;
      else if (!stall_f) m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("pc_f", pc_f, m_pc);
      chk("instr_d", instr_d, m_instr);
      chk("pc_d", pc_d, m_pcd);
      chk("pc_plus4_d", pc_plus4_d, m_pcd4);
      chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
      chk("trap", {31'b0, trap}, {31'b0, m_trap});
      chk("bad_addr", bad_addr, m_bad);
      chk("fetch_count", fetch_count, m_cnt);
    end
  end

  // Applies one cycle of inputs across the next rising edge; returns on the following negedge.
  task automatic drive(input logic r, input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt);
    rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src = src; pc_target = tgt;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'hA000_0001; rom[1] = 32'hA000_0002;
    rom[2] = 32'hA000_0003; rom[3] = 32'hA000_0004;
    rom[16] = 32'h0BAD_F00D;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_reset_pc", pc_f, 32'h0);
    chk("lit_reset_instr", instr_d, Nop);
    chk("lit_reset_valid", {31'b0, valid_d}, 32'h0);
    chk("lit_reset_count", fetch_count, 32'h0);

    run(1);
    chk("lit_first_valid", {31'b0, valid_d}, 32'h1);
    chk("lit_first_instr", instr_d, 32'hA000_0001);
    run(3);
    chk("lit_run_pc", pc_f, 32'd16);
    chk("lit_run_instr", instr_d, 32'hA000_0004);
    chk("lit_run_pcd", pc_d, 32'd12);
    chk("lit_run_pcd4", pc_plus4_d, 32'd16);
    chk("lit_run_count", fetch_count, 32'd4);

    // Stall both stages at pc_f = 8.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lit_stall_pc", pc_f, 32'd8);
    chk("lit_stall_instr", instr_d, 32'hA000_0002);
    chk("lit_stall_pcd", pc_d, 32'd4);
    chk("lit_stall_count", fetch_count, 32'd2);
    run(1);
    chk("lit_resume_pc", pc_f, 32'd12);
    chk("lit_resume_instr", instr_d, 32'hA000_0003);

    // Redirect with flush.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    chk("lit_redir_pc", pc_f, 32'h40);
    chk("lit_redir_instr", instr_d, Nop);
    chk("lit_redir_valid", {31'b0, valid_d}, 32'h0);
    run(1);
    chk("lit_target_instr", instr_d, 32'h0BAD_F00D);
    chk("lit_target_pcd", pc_d, 32'h40);
    chk("lit_target_count", fetch_count, 32'd4);

    // Redirect beats stall_f; flush beats stall_d.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    chk("lit_all_pc", pc_f, 32'h80);
    chk("lit_all_valid", {31'b0, valid_d}, 32'h0);
    chk("lit_all_count", fetch_count, 32'd4);

    // Misaligned redirect and sticky bad_addr.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    chk("lit_trap_pc", pc_f, TrapPc);
    chk("lit_trap_hi", {31'b0, trap}, 32'h1);
    chk("lit_trap_bad", bad_addr, 32'h0000_0102);
    run(1);
    chk("lit_trap_lo", {31'b0, trap}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
    run(1);
    chk("lit_bad_sticky", bad_addr, 32'h0000_0102);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h203);
    chk("lit_b2b_trap", {31'b0, trap}, 32'h1);
    chk("lit_b2b_bad", bad_addr, 32'h203);

    // Mid-run reset with count 7.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run(7);
    chk("lit_pre_rst_count", fetch_count, 32'd7);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("lit_rst_pc", pc_f, 32'h0);
    chk("lit_rst_count", fetch_count, 32'h0);
    chk("lit_rst_valid", {31'b0, valid_d}, 32'h0);
    chk("lit_rst_trap", {31'b0, trap}, 32'h0);
    chk("lit_rst_bad", bad_addr, 32'h0);

    // PC wrap.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(1);
    chk("lit_wrap_pc", pc_f, 32'h0);
    chk("lit_wrap_pcd4", pc_plus4_d, 32'h0);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, $urandom_range(0, 4095)};
      if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
